prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_byte_assembler.sv | 44 ++++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: state encoding, header size,
// and a small helper that decides which states count as "loading".
// Optional checksum support is selected with the LOADER_CSUM_EN macro.
package prog_loader_pkg;

    // Byte count of the little-endian word-count header
    localparam int unsigned HDR_BYTES = 4;

    // Lane index of the last byte of a 32-bit word
    localparam logic [1:0] LAST_LANE = 2'(HDR_BYTES - 1);

    // Loader state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_HDR  = 3'd0;
    localparam state_t ST_PAY  = 3'd1;
    localparam state_t ST_CSUM = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

    // True while a transfer is still in progress
    function automatic logic state_busy(input state_t s);
        return (s == ST_HDR) || (s == ST_PAY) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs a stream of bytes into little-endian 32-bit words.
// Byte k of a word lands in bits [8k+7:8k]; the lane counter wraps 3 -> 0 and a
// one-cycle strobe marks the cycle in which the completed word is readable.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        done
);

    logic [1:0]  lane_q;
    logic [31:0] word_q;
    logic        done_q;

    // Lane counter, lane register and word-complete strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                unique case (lane_q)
                    2'd0: word_q[7:0]   <= din;
                    2'd1: word_q[15:8]  <= din;
                    2'd2: word_q[23:16] <= din;
                    2'd3: word_q[31:24] <= din;
                    default: ;
                endcase
                lane_q <= lane_q + 2'd1;
                done_q <= (lane_q == LAST_LANE);
            end
        end
    end

    assign word = word_q;
    assign done = done_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: pulls a word-count header and a little-endian payload
// out of a UART receive buffer, writes it into program RAM and then releases
// the core from reset. With LOADER_CSUM_EN defined, a trailing XOR checksum byte
// is verified before the core is released.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM = 19
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [7:0]     rdata,
    input  logic           rx_ready,
    output logic           next,
    output logic           prog_we,
    output logic [MEM-3:0] prog_addr,
    output logic [31:0]    prog_din,
    output logic           core_rstn,
    output logic           busy,
    output logic           err
);

    // Largest legal word count: the whole program RAM
    localparam logic [32:0]    MAX_WORDS = 33'(1) << (MEM - 2);
    localparam logic [MEM-2:0] IDX_ONE   = (MEM - 1)'(1);

`ifdef LOADER_CSUM_EN
    localparam state_t ST_AFTER_PAY = ST_CSUM;
`else
    localparam state_t ST_AFTER_PAY = ST_DONE;
`endif

    state_t         state_q, state_d;
    logic           next_q, dead_q;
    logic [MEM-2:0] idx_q, n_q;
    logic           accepting, fetch, asm_en;
    logic [31:0]    word;
    logic           word_done;
    logic           prog_we_q;
    logic [MEM-3:0] prog_addr_q;
    logic [31:0]    prog_din_q;
    logic           core_rstn_q, busy_q, err_q;

`ifdef LOADER_CSUM_EN
    logic [7:0]     acc_q, csum_byte_q;
`endif

    // States that still want bytes; PAY stops once the last word is counted so
    // nothing past the payload is popped
    always_comb begin
        accepting = 1'b0;
        case (state_q)
            ST_HDR:  accepting = 1'b1;
            ST_PAY:  accepting = (idx_q != n_q);
`ifdef LOADER_CSUM_EN
            ST_CSUM: accepting = 1'b1;
`endif
            default: accepting = 1'b0;
        endcase
    end

    // The dead cycle after each pop lets the buffer's rx_ready catch up
    assign fetch = rx_ready && !next_q && !dead_q && accepting;

`ifdef LOADER_CSUM_EN
    assign asm_en = fetch && (state_q != ST_CSUM);
`else
    assign asm_en = fetch;
`endif

    prog_loader_byte_assembler u_byte_assembler (
        .clk  (clk),
        .rstn (rstn),
        .en   (asm_en),
        .din  (rdata),
        .word (word),
        .done (word_done)
    );

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (word_done) begin
                    // Full 32-bit compare so huge counts cannot alias after truncation
                    if ({1'b0, word} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (word == 32'd0) begin
                        state_d = ST_AFTER_PAY;
                    end else begin
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                // idx reaches N in the cycle the last word is being written
                if (idx_q == n_q) begin
                    state_d = ST_AFTER_PAY;
                end
            end
`ifdef LOADER_CSUM_EN
            ST_CSUM: begin
                if (next_q) begin
                    state_d = (csum_byte_q == acc_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // State, pop handshake, RAM write port and status registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_HDR;
            next_q      <= 1'b0;
            dead_q      <= 1'b0;
            idx_q       <= '0;
            n_q         <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_din_q  <= 32'd0;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_q    <= fetch;
            dead_q    <= next_q;
            prog_we_q <= 1'b0;
            if ((state_q == ST_HDR) && word_done && (state_d == ST_PAY)) begin
                n_q <= word[MEM-2:0];
            end
            if ((state_q == ST_PAY) && word_done) begin
                prog_we_q   <= 1'b1;
                prog_addr_q <= idx_q[MEM-3:0];
                prog_din_q  <= word;
                idx_q       <= idx_q + IDX_ONE;
            end
            core_rstn_q <= (state_q == ST_DONE);
            busy_q      <= state_busy(state_q);
            err_q       <= (state_q == ST_ERR);
        end
    end

`ifdef LOADER_CSUM_EN
    // Running XOR of payload bytes and capture of the trailing checksum byte
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q       <= 8'd0;
            csum_byte_q <= 8'd0;
        end else begin
            if (fetch && (state_q == ST_PAY)) begin
                acc_q <= acc_q ^ rdata;
            end
            if (fetch && (state_q == ST_CSUM)) begin
                csum_byte_q <= rdata;
            end
        end
    end
`endif

    assign next      = next_q;
    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_din  = prog_din_q;
    assign core_rstn = core_rstn_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a queue-based receive buffer model feeds
// byte streams, a monitor logs RAM writes, and each test compares against the
// outcome predicted from the stream format rules.
module tb_prog_loader;

    localparam int unsigned MEM  = 19;
    localparam longint unsigned MAXW = 64'd1 << (MEM - 2);

    logic           clk      = 1'b0;
    logic           rstn     = 1'b0;
    logic [7:0]     rdata    = 8'h00;
    logic           rx_ready = 1'b0;
    logic           next, prog_we, core_rstn, busy, err;
    logic [MEM-3:0] prog_addr;
    logic [31:0]    prog_din;

    always #5 clk = ~clk;

    prog_loader #(.MEM(MEM)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rdata     (rdata),
        .rx_ready  (rx_ready),
        .next      (next),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_din  (prog_din),
        .core_rstn (core_rstn),
        .busy      (busy),
        .err       (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  rx_q[$];
    logic [31:0] tx_words[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          gap = 0;
    bit          gaps_en = 0;
    int          cyc = 0, wr_cyc = -1, rise_cyc = -1, dbl_next = 0, pops = 0;
    bit          prev_next = 0, prev_core = 0;

    // Receive buffer model and write/handshake monitor
    initial forever begin
        @(negedge clk);
        cyc++;
        if (next === 1'b1) begin
            if (prev_next) dbl_next++;
            pops++;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            gap = gaps_en ? int'($urandom_range(0, 5)) : 0;
        end else if (gap > 0) begin
            gap--;
        end
        if (prog_we === 1'b1) begin
            wr_addr_q.push_back(int'(prog_addr));
            wr_data_q.push_back(prog_din);
            wr_cyc = cyc;
        end
        if ((core_rstn === 1'b1) && !prev_core) rise_cyc = cyc;
        prev_next = (next === 1'b1);
        prev_core = (core_rstn === 1'b1);
        rx_ready  = (rx_q.size() > 0) && (gap == 0);
        rdata     = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // Loader accepts the stream iff the count fits the RAM and the checksum agrees
    function automatic bit model_accepts(input longint unsigned n, input bit csum_ok);
        return (n <= MAXW) && csum_ok;
    endfunction

    task automatic push_word(input logic [31:0] w);
        rx_q.push_back(w[7:0]);
        rx_q.push_back(w[15:8]);
        rx_q.push_back(w[23:16]);
        rx_q.push_back(w[31:24]);
    endtask

    task automatic send_stream(input logic [31:0] n_hdr, input bit bad_csum);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        push_word(n_hdr);
        foreach (tx_words[i]) begin
            w = tx_words[i];
            push_word(w);
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
`ifdef LOADER_CSUM_EN
        rx_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
`else
        if (bad_csum) cs = 8'h00;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        rx_q.delete();
        gap = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc = -1;
        rise_cyc = -1;
        dbl_next = 0;
        pops = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            #1;
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp += 7;
        if (next !== 1'b0) begin n_bad++; $display("FAIL reset_next: got %b want 0", next); end
        if (prog_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", prog_we); end
        if (prog_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", prog_addr); end
        if (prog_din !== 32'd0) begin n_bad++; $display("FAIL reset_din: got %0h want 0", prog_din); end
        if (core_rstn !== 1'b0) begin n_bad++; $display("FAIL reset_core_rstn: got %b want 0", core_rstn); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single_word();
        bit to;
        do_reset();
        tx_words = '{32'h00A00513};
        send_stream(32'd1, 1'b0);
        wait_idle(400, to);
        n_cmp += 6;
        if (to) begin n_bad++; $display("FAIL single_timeout: busy=%b want 0", busy); end
        if (wr_addr_q.size() != 1) begin
            n_bad++; $display("FAIL single_count: got %0d want 1", wr_addr_q.size());
        end else begin
            if (wr_addr_q[0] != 0) begin n_bad++; $display("FAIL single_addr: got %0d want 0", wr_addr_q[0]); end
            if (wr_data_q[0] !== 32'h00A00513) begin
                n_bad++; $display("FAIL single_data: got %08h want 00a00513", wr_data_q[0]);
            end
        end
`ifndef LOADER_CSUM_EN
        if (rise_cyc - wr_cyc != 2) begin
            n_bad++; $display("FAIL single_release_lat: got %0d want 2", rise_cyc - wr_cyc);
        end
`else
        if (rise_cyc - wr_cyc < 2) begin
            n_bad++; $display("FAIL single_release_lat: got %0d want >=2", rise_cyc - wr_cyc);
        end
`endif
        if ((core_rstn !== 1'b1) || (err !== 1'b0)) begin
            n_bad++; $display("FAIL single_status: got core_rstn=%b err=%b want 1/0", core_rstn, err);
        end
    endtask

    task automatic check_stream(input string name, input int budget);
        bit to;
        wait_idle(budget, to);
        n_cmp += 4;
        if (to) begin n_bad++; $display("FAIL %s_timeout: busy=%b want 0", name, busy); end
        if (dbl_next != 0) begin n_bad++; $display("FAIL %s_next_b2b: got %0d want 0", name, dbl_next); end
        if (core_rstn !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", name, core_rstn); end
        if (wr_addr_q.size() != tx_words.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d want %0d", name, wr_addr_q.size(), tx_words.size());
        end else begin
            foreach (tx_words[i]) begin
                n_cmp++;
                if ((wr_addr_q[i] != i) || (wr_data_q[i] !== tx_words[i])) begin
                    n_bad++;
                    $display("FAIL %s_word%0d: got %0d:%08h want %0d:%08h", name, i,
                             wr_addr_q[i], wr_data_q[i], i, tx_words[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        gaps_en = 1'b1;
        tx_words.delete();
        for (int i = 0; i < 3; i++) tx_words.push_back($urandom);
        send_stream(32'd3, 1'b0);
        check_stream("gaps", 2000);
        gaps_en = 1'b0;
    endtask

    task automatic test_random_streams();
        int n;
        for (int t = 0; t < 4; t++) begin
            do_reset();
            gaps_en = $urandom_range(0, 1) != 0;
            n = int'($urandom_range(1, 5));
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back($urandom);
            send_stream(32'(n), 1'b0);
            check_stream("random", 3000);
        end
        gaps_en = 1'b0;
    endtask

    task automatic test_overflow(input logic [31:0] n_hdr);
        bit to;
        bit want_err;
        do_reset();
        tx_words.delete();
        send_stream(n_hdr, 1'b0);
        push_word($urandom);
        want_err = !model_accepts(longint'(n_hdr), 1'b1);
        wait_idle(300, to);
        n_cmp += 4;
        if (to) begin n_bad++; $display("FAIL ovf_timeout: busy=%b want 0", busy); end
        if (err !== want_err) begin n_bad++; $display("FAIL ovf_err: got %b want %b", err, want_err); end
        if (core_rstn !== 1'b0) begin n_bad++; $display("FAIL ovf_core_rstn: got %b want 0", core_rstn); end
        if (wr_addr_q.size() != 0) begin
            n_bad++; $display("FAIL ovf_writes: got %0d want 0", wr_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        bit reached;
        do_reset();
        push_word(32'd1);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (pops >= 6) begin reached = 1'b1; break; end
        end
        n_cmp++;
        if (!reached) begin n_bad++; $display("FAIL midrst_pops: got %0d want 6", pops); end
        do_reset();
        tx_words = '{$urandom};
        send_stream(32'd1, 1'b0);
        check_stream("midrst", 400);
    endtask

    task automatic test_zero_count();
        bit to;
        int pops_at_done;
        do_reset();
        tx_words.delete();
        send_stream(32'd0, 1'b0);
        wait_idle(300, to);
        pops_at_done = pops;
        push_word(32'hDEADBEEF);
        repeat (40) @(negedge clk);
        #1;
        n_cmp += 5;
        if (to) begin n_bad++; $display("FAIL zero_timeout: busy=%b want 0", busy); end
        if (core_rstn !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", core_rstn); end
        if (wr_addr_q.size() != 0) begin
            n_bad++; $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size());
        end
        if (pops != pops_at_done) begin
            n_bad++; $display("FAIL zero_pops: got %0d want %0d", pops, pops_at_done);
        end
        if (rx_q.size() != 4) begin n_bad++; $display("FAIL zero_left: got %0d want 4", rx_q.size()); end
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_checksum();
        bit to;
        bit want_ok;
        for (int b = 0; b < 2; b++) begin
            do_reset();
            tx_words = '{32'h11223344};
            send_stream(32'd1, b[0]);
            want_ok = model_accepts(64'd1, b == 0);
            wait_idle(400, to);
            n_cmp += 3;
            if (to) begin n_bad++; $display("FAIL csum_timeout: busy=%b want 0", busy); end
            if (core_rstn !== want_ok) begin
                n_bad++; $display("FAIL csum_done%0d: got %b want %b", b, core_rstn, want_ok);
            end
            if (err !== !want_ok) begin
                n_bad++; $display("FAIL csum_err%0d: got %b want %b", b, err, !want_ok);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_random_streams();
        test_overflow(32'hFFFFFFFF);
        test_overflow(32'(MAXW + 1));
        test_reset_mid_load();
        test_zero_count();
`ifdef LOADER_CSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
